seg_display_driver: RTL and testbench

Downstream consumer of the 2-bit display-clock digit select in the Adder design. It captures a binary sum and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It holds the result in a display register and drives the active-low anodes and segments of the 4-digit seven-segment display for whichever digit the display clock selects. The display is updated atomically, so the display never shows a partially converted value.

---
 rtl/seg_display_driver_if.sv | 23 ++
 rtl/seg_display_driver.sv | 132 +++++++++++++
 tb/tb_seg_display_driver.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seg_display_driver_if.sv
// Display-driver bus: binary value capture handshake plus the active-low display outputs.
// No logic; clk and reset stay as plain ports on the modules.
interface seg_display_driver_if #(
    parameter int WIDTH = 14
);
    logic [1:0]       digit_sel;
    logic [WIDTH-1:0] value;
    logic             load;
    logic             busy;
    logic [3:0]       an;
    logic [6:0]       seg;
    logic             dp;

    modport master (
        output digit_sel, value, load,
        input  busy, an, seg, dp
    );

    modport slave (
        input  digit_sel, value, load,
        output busy, an, seg, dp
    );
endinterface

// File: rtl/seg_display_driver.sv
// Binary-to-BCD (double-dabble) converter feeding a 4-digit active-low seven-segment display.
// Latency: WIDTH+2 cycles load-to-display; load ignored while busy. Macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg_display_driver #(
    parameter int WIDTH = 14
) (
    input  logic               clk,
    input  logic               reset,
    seg_display_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d, bcd_adj;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      disp_bcd_q, disp_bcd_d;
    logic             disp_ovf_q, disp_ovf_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       nib;

    function automatic logic [6:0] seg_enc(input logic [3:0] n);
        case (n)
            4'd0:    seg_enc = 7'b1000000;
            4'd1:    seg_enc = 7'b1111001;
            4'd2:    seg_enc = 7'b0100100;
            4'd3:    seg_enc = 7'b0110000;
            4'd4:    seg_enc = 7'b0011001;
            4'd5:    seg_enc = 7'b0010010;
            4'd6:    seg_enc = 7'b0000010;
            4'd7:    seg_enc = 7'b1111000;
            4'd8:    seg_enc = 7'b0000000;
            4'd9:    seg_enc = 7'b0010000;
            default: seg_enc = SEG_OFF;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        disp_bcd_d = disp_bcd_q;
        disp_ovf_d = disp_ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    bin_d   = bus.value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = (32'(bus.value) > 32'd9999);
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Whole result lands in one edge so the display never shows a partial value.
                disp_bcd_d = bcd_q;
                disp_ovf_d = ovf_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] upper;
`endif

    always_comb begin
        nib   = disp_bcd_q[{bus.digit_sel, 2'b00} +: 4];
        an_d  = ~(4'b0001 << bus.digit_sel);
        seg_d = disp_ovf_q ? SEG_DASH : seg_enc(nib);
`ifdef LEADING_ZERO_BLANK_EN
        upper = disp_bcd_q >> {bus.digit_sel, 2'b00};
        if (upper == 16'd0 && bus.digit_sel != 2'd0 && !disp_ovf_q) begin
            an_d  = 4'b1111;
            seg_d = SEG_OFF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            disp_bcd_q <= '0;
            disp_ovf_q <= 1'b0;
            an_q       <= 4'b1111;
            seg_q      <= SEG_OFF;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            disp_bcd_q <= disp_bcd_d;
            disp_ovf_q <= disp_ovf_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp   = 1'b1;
endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver; expectations queued with a due cycle and checked by a monitor.
module tb_seg_display_driver;
    localparam int WIDTH = 14;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S7 = 7'b1111000, S9 = 7'b0010000, SD = 7'b0111111;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] BLK_57 = 4'b1100;
    localparam logic [3:0] BLK_7  = 4'b1110;
    localparam logic [3:0] BLK_0  = 4'b1110;
`else
    localparam logic [3:0] BLK_57 = 4'b0000;
    localparam logic [3:0] BLK_7  = 4'b0000;
    localparam logic [3:0] BLK_0  = 4'b0000;
`endif

    typedef struct {
        int         due;
        bit         chk_out;
        logic [3:0] an;
        logic [6:0] seg;
        bit         chk_busy;
        logic       busy;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t  eq[$];
    string nq[$];

    seg_display_driver_if #(.WIDTH(WIDTH)) bus ();

    seg_display_driver #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int due, input bit co, input logic [3:0] an, input logic [6:0] seg,
                        input bit cb, input logic busy, input string nm);
        exp_t e;
        e.due = due; e.chk_out = co; e.an = an; e.seg = seg; e.chk_busy = cb; e.busy = busy;
        eq.push_back(e);
        nq.push_back(nm);
    endtask

    // One-cycle load pulse; full=1 also queues the busy-window checks for an uninterrupted conversion.
    task automatic start_load(input int v, input bit full, input string nm);
        bus.value = v[WIDTH-1:0];
        bus.load  = 1'b1;
        push(cyc + 1, 0, 4'h0, 7'h0, 1, 1'b1, {nm, "_busy_first"});
        if (full) begin
            push(cyc + WIDTH + 1, 0, 4'h0, 7'h0, 1, 1'b1, {nm, "_busy_last"});
            push(cyc + WIDTH + 2, 0, 4'h0, 7'h0, 1, 1'b0, {nm, "_busy_clear"});
        end
        tick();
        bus.load = 1'b0;
    endtask

    task automatic wait_done();
        repeat (WIDTH + 1) tick();
    endtask

    task automatic show(input string nm, input logic [27:0] segs, input logic [3:0] blank);
        logic [3:0] an_exp;
        for (int d = 0; d < 4; d++) begin
            bus.digit_sel = d[1:0];
            an_exp    = 4'b1111;
            an_exp[d] = 1'b0;
            if (blank[d]) push(cyc + 1, 1, 4'b1111, 7'b1111111, 0, 1'b0, $sformatf("%s_d%0d", nm, d));
            else          push(cyc + 1, 1, an_exp, segs[d*7 +: 7], 0, 1'b0, $sformatf("%s_d%0d", nm, d));
            tick();
        end
    endtask

    always @(negedge clk) begin
        for (int i = eq.size() - 1; i >= 0; i--) begin
            if (eq[i].due == cyc) begin
                if (eq[i].chk_out) begin
                    checks++;
                    if (bus.an !== eq[i].an || bus.seg !== eq[i].seg || bus.dp !== 1'b1) begin
                        errors++;
                        $display("FAIL %s: an=%b seg=%b dp=%b, required an=%b seg=%b dp=1",
                                 nq[i], bus.an, bus.seg, bus.dp, eq[i].an, eq[i].seg);
                    end
                end
                if (eq[i].chk_busy) begin
                    checks++;
                    if (bus.busy !== eq[i].busy) begin
                        errors++;
                        $display("FAIL %s: busy=%b, required %b", nq[i], bus.busy, eq[i].busy);
                    end
                end
                eq.delete(i);
                nq.delete(i);
            end else if (eq[i].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation not checked at cycle %0d", nq[i], eq[i].due);
                eq.delete(i);
                nq.delete(i);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.load      = 1'b0;
        bus.value     = '0;
        bus.digit_sel = 2'd0;

        for (int r = 0; r < 3; r++) begin
            tick();
            push(cyc, 1, 4'b1111, 7'b1111111, 1, 1'b0, $sformatf("reset_hold%0d", r));
        end
        reset = 1'b0;
        push(cyc + 1, 1, 4'b1110, S0, 1, 1'b0, "reset_release");
        tick();

        start_load(1234, 1, "v1234");
        wait_done();
        show("v1234", {S1, S2, S3, S4}, 4'b0000);

        start_load(12000, 1, "ovf12000");
        wait_done();
        show("ovf12000", {SD, SD, SD, SD}, 4'b0000);

        start_load(9999, 1, "v9999");
        wait_done();
        show("v9999", {S9, S9, S9, S9}, 4'b0000);

        start_load(57, 1, "v57");
        tick();
        tick();
        bus.value = 14'd8000;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        repeat (WIDTH - 2) tick();
        show("ignored8000", {S0, S0, S5, S7}, BLK_57);

        start_load(4321, 0, "abort4321");
        repeat (4) tick();
        reset = 1'b1;
        push(cyc + 1, 0, 4'h0, 7'h0, 1, 1'b0, "abort_busy");
        tick();
        reset = 1'b0;
        show("abort_cleared", {S0, S0, S0, S0}, BLK_0);

        start_load(4321, 1, "v4321");
        wait_done();
        show("v4321", {S4, S3, S2, S1}, 4'b0000);

        start_load(7, 1, "v7");
        wait_done();
        show("v7", {S0, S0, S0, S7}, BLK_7);

        tick();
        tick();
        if (eq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: %0d expectations unchecked, required 0", eq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
